// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI local-bus responder.
package dac_spi_pkg;

  localparam int FRAME_W = 24;
  localparam int DATA_W  = 16;
  localparam int ADR_W   = 7;
  localparam int RNW_POS = 23;
  localparam int TMR_W   = 16;

  localparam int CLK_DIV_DEF  = 4;
  localparam int CS_SETUP_DEF = 2;
  localparam int CS_HOLD_DEF  = 2;
  localparam int CS_GAP_DEF   = 4;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

endpackage

// File: rtl/dac_spi_clkgen.sv
// SCLK divider: half period CLK_DIV cycles, starts low, held cleared while disabled.
module dac_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tc;

  assign tc       = (cnt_q == '0);
  assign rise_stb = en && tc && !sclk;
  assign fall_stb = en && tc && sclk;

  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      cnt_q <= CW'(CLK_DIV - 1);
      sclk  <= 1'b0;
    end else if (tc) begin
      cnt_q <= CW'(CLK_DIV - 1);
      sclk  <= !sclk;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_lb_slave.sv
// DAC SPI local-bus responder: one REQ/ACK request becomes one 24-bit mode-0 frame.
// Build option SPI_3WIRE_EN releases SDO during the read data phase (shared SDIO pin).
//
// state | meaning
// IDLE  | waiting for LB_REQ, CSn high
// SETUP | CSn low, CS_SETUP cycles before first SCLK
// SHIFT | 24 bit periods, SDO out / SDI sampled on SCLK rise
// HOLD  | SCLK low, CSn low for CS_HOLD cycles
// DONE  | CSn high, LB_ACK pulse, LB_RDAT loaded
// GAP   | CSn high >= CS_GAP cycles and until LB_REQ low
module dac_spi_lb_slave
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF,
  parameter int CS_GAP   = CS_GAP_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LB_REQ,
  input  logic              LB_RNW,
  input  logic [ADR_W-1:0]  LB_ADR,
  input  logic [DATA_W-1:0] LB_WDAT,
  output logic              LB_ACK,
  output logic [DATA_W-1:0] LB_RDAT,
  output logic              BUSY,
  output logic              SPI_CSn,
  output logic              SPI_SCLK,
  output logic              SPI_SDO,
  output logic              SPI_SDO_OE,
  input  logic              SPI_SDI
);

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [4:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   frame_q;
  logic [DATA_W-1:0]    rx_q;
  logic                 rnw_q;
  logic                 sclk, rise_stb, fall_stb;
  logic                 sdo_raw;

  dac_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state_q == SHIFT),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (LB_REQ) begin
        state_d = SETUP;
        tmr_d   = TMR_W'(CS_SETUP - 1);
        bit_d   = '0;
      end
      SETUP: if (tmr_q == '0) state_d = SHIFT;
             else tmr_d = tmr_q - 1'b1;
      SHIFT: if (fall_stb) begin
        if (bit_q == 5'(FRAME_W - 1)) begin
          state_d = HOLD;
          tmr_d   = TMR_W'(CS_HOLD - 1);
        end else begin
          bit_d = bit_q + 5'd1;
        end
      end
      HOLD: if (tmr_q == '0) state_d = DONE;
            else tmr_d = tmr_q - 1'b1;
      DONE: begin
        state_d = GAP;
        tmr_d   = TMR_W'(CS_GAP - 1);
      end
      GAP: if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
           else if (!LB_REQ) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      rx_q    <= '0;
      rnw_q   <= 1'b0;
      LB_RDAT <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      if (state_q == IDLE && LB_REQ) begin
        frame_q <= {LB_RNW, LB_ADR, LB_WDAT};
        rnw_q   <= LB_RNW;
      end else if (state_q == SHIFT && fall_stb) begin
        frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
      end
      if (state_q == SHIFT && rise_stb)
        rx_q <= {rx_q[DATA_W-2:0], SPI_SDI};
      if (state_q == HOLD && state_d == DONE)
        LB_RDAT <= rnw_q ? rx_q : '0;
    end
  end

  assign BUSY     = (state_q != IDLE);
  assign LB_ACK   = (state_q == DONE);
  assign SPI_CSn  = !(state_q == SETUP || state_q == SHIFT || state_q == HOLD);
  assign SPI_SCLK = sclk;
  assign sdo_raw  = (state_q == SHIFT) ? frame_q[RNW_POS] : 1'b0;

`ifdef SPI_3WIRE_EN
  // Bus turnaround: bit_q index 8 is data bit 15, the first bit driven by the DAC.
  logic rd_turn;
  assign rd_turn    = rnw_q && ((state_q == SHIFT && bit_q >= 5'(FRAME_W - DATA_W))
                                || state_q == HOLD);
  assign SPI_SDO_OE = !rd_turn;
  assign SPI_SDO    = rd_turn ? 1'b0 : sdo_raw;
`else
  assign SPI_SDO_OE = 1'b1;
  assign SPI_SDO    = sdo_raw;
`endif

endmodule

// File: tb/tb_dac_spi_lb_slave.sv
// Scoreboard bench for dac_spi_lb_slave at default timing (ACK 197 cycles after accept).
module tb_dac_spi_lb_slave;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LB_REQ = 1'b0;
  logic        LB_RNW = 1'b0;
  logic [6:0]  LB_ADR = '0;
  logic [15:0] LB_WDAT = '0;
  logic        SPI_SDI = 1'b0;
  logic        LB_ACK, BUSY, SPI_CSn, SPI_SCLK, SPI_SDO, SPI_SDO_OE;
  logic [15:0] LB_RDAT;

  always #5 CLK = ~CLK;

  dac_spi_lb_slave dut (
    .CLK(CLK), .RST(RST), .LB_REQ(LB_REQ), .LB_RNW(LB_RNW), .LB_ADR(LB_ADR),
    .LB_WDAT(LB_WDAT), .LB_ACK(LB_ACK), .LB_RDAT(LB_RDAT), .BUSY(BUSY),
    .SPI_CSn(SPI_CSn), .SPI_SCLK(SPI_SCLK), .SPI_SDO(SPI_SDO),
    .SPI_SDO_OE(SPI_SDO_OE), .SPI_SDI(SPI_SDI)
  );

`ifdef SPI_3WIRE_EN
  localparam int OE_RD = 130;  // 16 bits * 8 cycles + 2 hold cycles
`else
  localparam int OE_RD = 0;
`endif

  typedef struct {
    logic [23:0] frame;
    logic [15:0] rdat;
    int          oe_low;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_cur;
  int          checks = 0, errors = 0;
  int          ack_cnt = 0, nrise = 0, lat = 0, oe_low = 0, cs_high = 0, cs_falls = 0;
  logic [23:0] sh = '0;
  logic [23:0] sdi_pat = '0;
  logic        busy_p = 1'b0, sclk_p = 1'b0, cs_p = 1'b1, seen_rise = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: frame capture, SDI model, scoreboard pop on ACK.
  always @(negedge CLK) begin
    if (BUSY === 1'b1 && busy_p === 1'b0) begin
      lat = 1; nrise = 0; oe_low = 0; sh = '0;
    end else if (BUSY === 1'b1) begin
      lat++;
    end
    if (BUSY === 1'b1 && SPI_SDO_OE === 1'b0) oe_low++;
    if (SPI_SCLK === 1'b1 && sclk_p === 1'b0) begin
      sh = {sh[22:0], SPI_SDO};
      nrise++;
    end
    if (SPI_CSn === 1'b0 && cs_p === 1'b1) begin
      cs_falls++;
      if (seen_rise) begin
        checks++;
        if (cs_high < 4) begin
          errors++;
          $display("FAIL cs_gap: got %0d cycles high, need at least 4", cs_high);
        end
      end
    end
    if (SPI_CSn === 1'b1 && cs_p === 1'b0) seen_rise = 1'b1;
    if (SPI_CSn === 1'b1) cs_high++; else cs_high = 0;
    if (LB_ACK === 1'b1) begin
      ack_cnt++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        e_cur = sb.pop_front();
        chk("frame_sdo", 32'(sh), 32'(e_cur.frame));
        chk("sclk_rises", nrise, 24);
        chk("ack_latency", lat, 197);
        chk("rdat_at_ack", 32'(LB_RDAT), 32'(e_cur.rdat));
        chk("oe_low_cycles", oe_low, e_cur.oe_low);
      end
    end
    SPI_SDI = (nrise < 24) ? sdi_pat[23 - nrise] : 1'b0;
    busy_p = BUSY; sclk_p = SPI_SCLK; cs_p = SPI_CSn;
  end

  task automatic tick;
    @(negedge CLK); #1;
  endtask

  task automatic issue(input logic rnw, input logic [6:0] adr, input logic [15:0] wdat);
    LB_RNW = rnw; LB_ADR = adr; LB_WDAT = wdat; LB_REQ = 1'b1;
    tick;
  endtask

  task automatic wait_ack(input string name);
    int n0 = ack_cnt;
    int k = 0;
    while (ack_cnt == n0 && k < 400) begin tick; k++; end
    if (ack_cnt == n0) begin
      checks++; errors++;
      $display("FAIL %s: got no ack within 400 cycles, expected one", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (BUSY !== 1'b0 && k < 100) begin tick; k++; end
    chk(name, 32'(BUSY), 32'h0);
  endtask

  task automatic wait_rise(input int n, input string name);
    int k = 0;
    while (nrise < n && k < 300) begin tick; k++; end
    chk(name, 32'(nrise >= n), 32'h1);
  endtask

  initial begin
    int f0, a0;
    repeat (3) tick;
    RST = 1'b0;
    tick;
    chk("rst_ack",   32'(LB_ACK),     32'h0);
    chk("rst_rdat",  32'(LB_RDAT),    32'h0);
    chk("rst_busy",  32'(BUSY),       32'h0);
    chk("rst_csn",   32'(SPI_CSn),    32'h1);
    chk("rst_sclk",  32'(SPI_SCLK),   32'h0);
    chk("rst_sdo",   32'(SPI_SDO),    32'h0);
    chk("rst_oe",    32'(SPI_SDO_OE), 32'h1);

    // Write, default timing
    sb.push_back('{24'h12A5C3, 16'h0000, 0});
    issue(1'b0, 7'h12, 16'hA5C3);
    wait_ack("write_ack");
    LB_REQ = 1'b0;
    wait_idle("write_idle");

    // Read with SDI data, REQ held 50 cycles past ACK
    sdi_pat = 24'h003C5A;
    sb.push_back('{24'h850000, 16'h3C5A, OE_RD});
    issue(1'b1, 7'h05, 16'h0000);
    wait_ack("read_ack");
    f0 = cs_falls;
    repeat (50) tick;
    chk("req_hold_no_frame", cs_falls, f0);
    chk("req_hold_busy", 32'(BUSY), 32'h1);
    chk("req_hold_csn", 32'(SPI_CSn), 32'h1);
    LB_REQ = 1'b0;
    wait_idle("read_idle");
    chk("rdat_held_idle", 32'(LB_RDAT), 32'h3C5A);

    // Reset during bit 10 of a write
    sdi_pat = '0;
    issue(1'b0, 7'h7F, 16'hFFFF);
    wait_rise(11, "reach_bit10");
    chk("rdat_held_midframe", 32'(LB_RDAT), 32'h3C5A);
    RST = 1'b1; LB_REQ = 1'b0;
    tick;
    RST = 1'b0;
    chk("abort_csn",  32'(SPI_CSn),  32'h1);
    chk("abort_sclk", 32'(SPI_SCLK), 32'h0);
    chk("abort_busy", 32'(BUSY),     32'h0);
    chk("abort_ack",  32'(LB_ACK),   32'h0);
    chk("abort_rdat", 32'(LB_RDAT),  32'h0);
    a0 = ack_cnt;
    repeat (20) tick;
    chk("abort_no_ack", ack_cnt, a0);

    // Inputs trashed and REQ dropped at bit 5: latched frame still sent
    sb.push_back('{24'h331234, 16'h0000, 0});
    issue(1'b0, 7'h33, 16'h1234);
    wait_rise(6, "reach_bit5");
    LB_ADR = '0; LB_WDAT = '0; LB_REQ = 1'b0;
    wait_ack("midchange_ack");
    wait_idle("midchange_idle");

    // Back-to-back request, exercises minimum CSn gap
    sb.push_back('{24'h40BEEF, 16'h0000, 0});
    issue(1'b0, 7'h40, 16'hBEEF);
    wait_ack("b2b_ack");
    LB_REQ = 1'b0;
    wait_idle("b2b_idle");

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_spi_lb_slave.md
Name: dac_spi_lb_slave

Overview:
- Responder end of the DAC SPI local-bus: accepts one REQ/RNW/ADR/WDAT request from the DAC register block and serialises it as a 24-bit SPI frame to one DAC chip.
- Returns ACK plus RDAT captured from the frame data phase.
- One instance per DAC. The top wrapper ties each instance to one element of the SPI_LB_BUS array; this block exposes plain ports.

Parameters:
- CLK_DIV, 4, half SCLK period in CLK cycles (>=1); bit period = 2*CLK_DIV.
- CS_SETUP, 2, CLK cycles CSn low before the first SCLK low phase (>=1).
- CS_HOLD, 2, CLK cycles CSn stays low after the last bit (>=1).
- CS_GAP, 4, minimum CLK cycles CSn high between frames (>=1).

Ports:
- CLK  in  1  single clock, shared with the register bus.
- RST  in  1  synchronous reset, active-high.
- LB_REQ  in  1  request level, held by the master until ACK.
- LB_RNW  in  1  1 = read, 0 = write.
- LB_ADR  in  7  register address.
- LB_WDAT  in  16  write data.
- LB_ACK  out  1  one-cycle completion pulse.
- LB_RDAT  out  16  read data, valid from ACK onward.
- BUSY  out  1  high from accept through end of gap.
- SPI_CSn  out  1  chip select, active-low.
- SPI_SCLK  out  1  serial clock, idle low (mode 0).
- SPI_SDO  out  1  serial data out.
- SPI_SDO_OE  out  1  SDO output enable.
- SPI_SDI  in  1  serial data in.

Behaviour:
- Clocking and reset: one clock (CLK). Reset (RST) is synchronous and active-high.
- Reset values: LB_ACK=0, LB_RDAT=0, BUSY=0, SPI_CSn=1, SPI_SCLK=0, SPI_SDO=0, SPI_SDO_OE=1. FSM goes to IDLE.
- Frame: {RNW, ADR[6:0], WDAT[15:0]}, 24 bits, MSB first. ADR, WDAT and RNW are latched at accept. Later input changes are ignored.
- IDLE: LB_REQ=1 seen at cycle 0 → latch inputs, BUSY=1. Cycle 1: CSn=0, enter SETUP.
- SETUP: count CS_SETUP cycles, then SHIFT.
- SHIFT, per bit:
  - SDO updated at the start of the bit period, SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - SDI sampled in the CLK cycle where SCLK goes high.
  - 24 bits total.
  - A bit counter of width 5 terminates at 23. No wrap.
- HOLD: SCLK=0, CSn stays low for CS_HOLD cycles.
- Completion: CSn=1 and LB_ACK=1 in the same cycle. LB_RDAT is loaded with the last 16 sampled bits on reads and 16'h0 on writes.
  - ACK cycle = 1 + CS_SETUP + 48*CLK_DIV + CS_HOLD after accept. With defaults this is 197.
- GAP: CSn high for at least CS_GAP cycles and until LB_REQ is observed low. Then BUSY=0 and IDLE.
  - A REQ still high after ACK never starts a second frame.
- LB_REQ deasserted mid-frame: ignored. The frame completes and ACK is still issued.
- RST mid-frame: immediate return to reset values. No ACK for the aborted request. A partial frame is visible as CSn rising.
- LB_RDAT holds its value between ACKs.

Optional Feature:
- Macro SPI_3WIRE_EN, for a shared SDIO pin.
- Defined: SPI_SDO_OE=0 from the start of data bit 15 of a read frame until CSn rises. SDO is held 0 while OE=0. OE=1 for all other times and for write frames. The top wrapper routes the IOBUF output to SPI_SDI.
- Undefined: SPI_SDO_OE is constant 1. Behaviour is otherwise identical.

Decomposition:
- Package dac_spi_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD, DONE, GAP};
  - FRAME_W=24, DATA_W=16, ADR_W=7;
  - RNW_POS=23;
  - default timing constants.
- Sub-module dac_spi_clkgen: CLK_DIV divider producing sclk level, rise_stb and fall_stb. It is enabled only in SHIFT and cleared on RST.

Test Plan:
- Write, defaults. ADR=7'h12, WDAT=16'hA5C3, RNW=0.
  - Expect 24 SCLK rises with sampled SDO = 24'h12A5C3.
  - Expect a single ACK at cycle 197 after accept, and LB_RDAT=16'h0000.
- Read. ADR=7'h05, RNW=1, SDI model drives 16'h3C5A in the data phase.
  - Expect header bits 8'h85.
  - Expect LB_RDAT=16'h3C5A at ACK, held until the next ACK.
- REQ kept high 50 cycles after ACK.
  - Expect no second CSn fall until REQ drops.
  - Next frame starts no earlier than CS_GAP cycles after CSn rises.
- RST pulsed during SHIFT bit 10.
  - Expect next cycle CSn=1, SCLK=0, BUSY=0, no ACK, LB_RDAT=0.
  - A fresh request afterwards completes normally.
- Inputs changed mid-frame: ADR/WDAT set to 0 and REQ dropped at bit 5.
  - Frame still carries the latched values and ACK occurs.
- SPI_3WIRE_EN, read frame.
  - Expect OE=0 for exactly the 16 data bit periods plus HOLD.
  - Expect OE=1 throughout a write frame.
